// File: rtl/mips_16_debug_monitor.sv
// Run-control / debug monitor for mips_16: PC breakpoints plus a cycle timeout halt the core,
// then every register-file entry is streamed out over a valid/ready dump port until resume.
module mips_16_debug_monitor #(
  parameter int PC_WIDTH       = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int NUM_BP         = 4,
  parameter int CNT_WIDTH      = 16,
  localparam int BP_IDX_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      monitor_en,
  input  logic [PC_WIDTH-1:0]       pc,
  input  logic                      bp_wr_en,
  input  logic [BP_IDX_W-1:0]       bp_wr_idx,
  input  logic [PC_WIDTH-1:0]       bp_wr_pc,
  input  logic                      bp_wr_valid,
  input  logic [CNT_WIDTH-1:0]      timeout_limit,
  input  logic                      resume,
  output logic                      halt,
  output logic [1:0]                cause,
  output logic [BP_IDX_W-1:0]       hit_idx,
  output logic [PC_WIDTH-1:0]       hit_pc,
  output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [REG_ADDR_WIDTH-1:0] dump_idx,
  output logic [DATA_WIDTH-1:0]     dump_data,
  output logic [CNT_WIDTH-1:0]      cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_HALTED} state_t;

  state_t                            state_q;
  logic [NUM_BP-1:0]                 bp_vld_q;
  logic [NUM_BP-1:0][PC_WIDTH-1:0]   bp_pc_q;
  logic                              halt_q, dump_valid_q, supp_q, to_done_q;
  logic [1:0]                        cause_q;
  logic [BP_IDX_W-1:0]               hit_idx_q;
  logic [PC_WIDTH-1:0]               hit_pc_q;
  logic [REG_ADDR_WIDTH-1:0]         dump_idx_q;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;

  logic [NUM_BP-1:0]   bp_match;
  logic [BP_IDX_W-1:0] bp_sel;
  logic                bp_hit, to_hit, wr_ok;

  for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
    assign bp_match[g] = bp_vld_q[g] && (bp_pc_q[g] == pc);
  end

  always_comb begin
    bp_sel = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (bp_match[i]) bp_sel = BP_IDX_W'(i);
  end

  // After resume the core is still parked on hit_pc; mask breakpoints until it moves off.
  assign bp_hit = (|bp_match) && !(supp_q && (pc == hit_pc_q));
  assign to_hit = (timeout_limit != '0) && !to_done_q && (cnt_q == timeout_limit);
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign wr_ok  = bp_wr_en && ({1'b0, bp_wr_idx} < (BP_IDX_W + 1)'(NUM_BP));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bp_vld_q     <= '0;
      bp_pc_q      <= '0;
      halt_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      supp_q       <= 1'b0;
      to_done_q    <= 1'b0;
      cause_q      <= '0;
      hit_idx_q    <= '0;
      hit_pc_q     <= '0;
      dump_idx_q   <= '0;
      cnt_q        <= '0;
    end else begin
      if (wr_ok) begin
        bp_vld_q[bp_wr_idx] <= bp_wr_valid;
        bp_pc_q[bp_wr_idx]  <= bp_wr_pc;
      end
      if (supp_q && (pc != hit_pc_q) && (state_q != S_HALTED)) supp_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (monitor_en) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            to_done_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (!monitor_en) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (bp_hit || to_hit) begin
              state_q      <= S_DUMP;
              halt_q       <= 1'b1;
              cause_q      <= {to_hit, bp_hit};
              hit_pc_q     <= pc;
              dump_idx_q   <= '0;
              dump_valid_q <= 1'b1;
              if (bp_hit) hit_idx_q <= bp_sel;
              if (to_hit) to_done_q <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            dump_idx_q <= dump_idx_q + 1'b1;
            if (&dump_idx_q) begin
              state_q      <= S_HALTED;
              dump_valid_q <= 1'b0;
            end
          end
        end
        S_HALTED: begin
          if (resume) begin
            halt_q  <= 1'b0;
            supp_q  <= 1'b1;
            state_q <= monitor_en ? S_RUN : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign halt        = halt_q;
  assign cause       = cause_q;
  assign hit_idx     = hit_idx_q;
  assign hit_pc      = hit_pc_q;
  assign reg_rd_addr = dump_idx_q;
  assign dump_idx    = dump_idx_q;
  assign dump_valid  = dump_valid_q;
  assign dump_data   = reg_rd_data;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mips_16_debug_monitor.sv
// Directed bench for mips_16_debug_monitor: stimulus pushes expected dump beats into a
// scoreboard queue; a negedge monitor pops and compares each accepted beat.
module tb_mips_16_debug_monitor;

  logic        clk = 1'b0;
  logic        rst, monitor_en, bp_wr_en, bp_wr_valid, resume;
  logic [7:0]  pc, bp_wr_pc;
  logic [1:0]  bp_wr_idx;
  logic [15:0] timeout_limit;
  logic        halt, dump_valid;
  logic        dump_ready = 1'b1;
  logic [1:0]  cause, hit_idx;
  logic [7:0]  hit_pc;
  logic [2:0]  reg_rd_addr, dump_idx;
  logic [15:0] reg_rd_data, dump_data, cycle_count;

  logic [15:0] reg_array [8];
  assign reg_rd_data = reg_array[reg_rd_addr];

  typedef struct { logic [2:0] idx; logic [15:0] data; } beat_t;
  beat_t sb[$];

  int n_tests = 0, n_fail = 0, nbeats = 0, rdy_mode = 0;
  logic        held = 1'b0;
  logic [2:0]  h_idx;
  logic [15:0] h_data;

  mips_16_debug_monitor dut (
    .clk(clk), .rst(rst), .monitor_en(monitor_en), .pc(pc),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_pc(bp_wr_pc), .bp_wr_valid(bp_wr_valid),
    .timeout_limit(timeout_limit), .resume(resume), .halt(halt), .cause(cause),
    .hit_idx(hit_idx), .hit_pc(hit_pc), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Consumer: 0 = always ready, 1 = toggle every cycle, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dump_ready = 1'b1;
      1:       dump_ready = ~dump_ready;
      default: dump_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst && dump_valid) begin
      if (held) begin
        n_tests++;
        if (dump_idx !== h_idx || dump_data !== h_data) begin
          n_fail++;
          $display("FAIL stall_hold: got idx %0d data %h, held idx %0d data %h", dump_idx, dump_data, h_idx, h_data);
        end
      end
      if (dump_ready) begin
        beat_t e;
        held = 1'b0;
        nbeats++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got idx %0d data %h, expected no beat", dump_idx, dump_data);
        end else begin
          e = sb.pop_front();
          if (dump_idx !== e.idx || dump_data !== e.data) begin
            n_fail++;
            $display("FAIL beat: got idx %0d data %h, expected idx %0d data %h", dump_idx, dump_data, e.idx, e.data);
          end
        end
      end else begin
        held = 1'b1;
        h_idx = dump_idx;
        h_data = dump_data;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wr_bp(input logic [1:0] idx, input logic [7:0] a, input logic v);
    bp_wr_en = 1'b1; bp_wr_idx = idx; bp_wr_pc = a; bp_wr_valid = v;
    cyc(1);
    bp_wr_en = 1'b0;
  endtask

  task automatic set_regs(input logic [15:0] base);
    for (int i = 0; i < 8; i++) reg_array[i] = base + 16'(i) * 16'h0101;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.idx = 3'(i);
      b.data = reg_array[i];
      sb.push_back(b);
    end
  endtask

  task automatic wait_dump(input int budget);
    int b = 0;
    while ((dump_valid || sb.size() != 0) && b < budget) begin cyc(1); b++; end
    n_tests++;
    if (dump_valid || sb.size() != 0) begin
      n_fail++;
      $display("FAIL dump_timeout: %0d beats outstanding, expected 0", sb.size());
    end
  endtask

  task automatic do_resume(input logic en);
    monitor_en = en;
    resume = 1'b1;
    cyc(1);
    resume = 1'b0;
  endtask

  initial begin
    int nb0;
    rst = 1'b0; monitor_en = 1'b0; pc = '0; bp_wr_en = 1'b0; bp_wr_idx = '0;
    bp_wr_pc = '0; bp_wr_valid = 1'b0; timeout_limit = '0; resume = 1'b0;
    set_regs(16'h1000);
    cyc(2);
    chk("rst_halt", halt, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_cause", cause, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_rdaddr", reg_rd_addr, 0);
    rst = 1'b1;

    // Breakpoint in slot 2 at pc 6
    wr_bp(2, 8'd6, 1'b1);
    monitor_en = 1'b1;
    cyc(1);
    for (int p = 0; p < 6; p++) begin pc = 8'(p); cyc(1); end
    chk("bp_no_early_halt", halt, 0);
    pc = 8'd6; push_dump(); cyc(1);
    chk("bp_halt", halt, 1);
    chk("bp_cause", cause, 1);
    chk("bp_hit_idx", hit_idx, 2);
    chk("bp_hit_pc", hit_pc, 6);
    chk("bp_valid", dump_valid, 1);
    chk("bp_rdaddr0", reg_rd_addr, 0);
    wait_dump(40);
    chk("bp_halted_halt", halt, 1);
    chk("bp_count", cycle_count, 7);

    // Resume while parked on pc 6: suppressed; re-reach pc 6 after moving off
    do_resume(1'b1);
    chk("res_halt_low", halt, 0);
    cyc(3);
    chk("supp_no_retrigger", halt, 0);
    pc = 8'd7; cyc(1);
    set_regs(16'hA05A);
    pc = 8'd6; push_dump(); cyc(1);
    chk("retrig_halt", halt, 1);
    chk("retrig_hit_idx", hit_idx, 2);
    chk("retrig_count", cycle_count, 12);
    wait_dump(40);
    do_resume(1'b0);
    chk("res_idle_halt", halt, 0);
    cyc(2);
    chk("idle_count_held", cycle_count, 12);

    // Slots 0 and 3 at pc 10, toggling ready
    wr_bp(2, 8'd6, 1'b0);
    wr_bp(0, 8'd10, 1'b1);
    wr_bp(3, 8'd10, 1'b1);
    rdy_mode = 1;
    pc = 8'd8; monitor_en = 1'b1;
    cyc(2);
    pc = 8'd9; cyc(1);
    set_regs(16'h3C01);
    pc = 8'd10; push_dump(); nb0 = nbeats; cyc(1);
    chk("prio_cause", cause, 1);
    chk("prio_hit_idx", hit_idx, 0);
    chk("prio_hit_pc", hit_pc, 10);
    chk("prio_count", cycle_count, 3);
    wait_dump(60);
    chk("toggle_beats", nbeats - nb0, 8);
    rdy_mode = 0;
    do_resume(1'b0);

    // Breakpoint and timeout in the same cycle; config write while halted
    wr_bp(0, 8'd0, 1'b0);
    wr_bp(3, 8'd20, 1'b1);
    timeout_limit = 16'd5;
    pc = 8'd15; monitor_en = 1'b1;
    cyc(1);
    for (int p = 15; p < 20; p++) begin pc = 8'(p); cyc(1); end
    set_regs(16'h7700);
    pc = 8'd20; push_dump(); cyc(1);
    chk("both_cause", cause, 3);
    chk("both_hit_idx", hit_idx, 3);
    chk("both_count", cycle_count, 6);
    wait_dump(40);
    wr_bp(1, 8'd22, 1'b1);
    wr_bp(3, 8'd99, 1'b1);
    chk("cfg_hit_idx_kept", hit_idx, 3);
    chk("cfg_hit_pc_kept", hit_pc, 20);
    chk("cfg_halt_kept", halt, 1);
    do_resume(1'b1);
    cyc(1);
    chk("cfg_no_trig_pc20", halt, 0);
    pc = 8'd21; cyc(1);
    set_regs(16'h0F0F);
    pc = 8'd22; push_dump(); cyc(1);
    chk("cfg_new_cause", cause, 1);
    chk("cfg_new_hit_idx", hit_idx, 1);
    chk("cfg_new_hit_pc", hit_pc, 22);
    chk("cfg_new_count", cycle_count, 9);
    wait_dump(40);
    do_resume(1'b0);

    // Timeout only at 400
    wr_bp(1, 8'd0, 1'b0);
    wr_bp(3, 8'd0, 1'b0);
    timeout_limit = 16'd400;
    pc = 8'd50; monitor_en = 1'b1;
    cyc(1);
    cyc(400);
    chk("to_not_yet", halt, 0);
    chk("to_count400", cycle_count, 400);
    set_regs(16'hBEEF);
    push_dump(); cyc(1);
    chk("to_halt", halt, 1);
    chk("to_cause", cause, 2);
    chk("to_hit_idx_kept", hit_idx, 1);
    chk("to_hit_pc", hit_pc, 50);
    chk("to_count401", cycle_count, 401);
    wait_dump(40);
    do_resume(1'b1);
    timeout_limit = 16'd450;
    cyc(100);
    chk("to_once", halt, 0);
    chk("to_count_cont", cycle_count, 501);
    monitor_en = 1'b0; cyc(1);

    // Reset in the middle of a stalled dump
    rdy_mode = 2;
    wr_bp(0, 8'd30, 1'b1);
    pc = 8'd30; monitor_en = 1'b1;
    cyc(2);
    chk("mid_halt", halt, 1);
    chk("mid_valid", dump_valid, 1);
    rst = 1'b0;
    cyc(1);
    chk("mid_rst_halt", halt, 0);
    chk("mid_rst_valid", dump_valid, 0);
    chk("mid_rst_count", cycle_count, 0);
    chk("mid_rst_hit_pc", hit_pc, 0);
    chk("mid_rst_cause", cause, 0);
    cyc(1);
    rst = 1'b1; rdy_mode = 0;
    cyc(5);
    chk("post_rst_bp_cleared", halt, 0);
    monitor_en = 1'b0;
    cyc(2);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_16_debug_monitor.md
Name: mips_16_debug_monitor

Overview:
Synthesizable run-control and debug monitor for the mips_16 core. It watches the core PC against NUM_BP programmable breakpoints and a cycle-count timeout. On a trigger it asserts halt to stall the core, then streams every register-file entry out through a valid/ready dump port. It holds the core halted until resume. It sits beside mips_16_core_top and uses a dedicated register-file read port and the core stall input.

Parameters:
PC_WIDTH, 8, core PC width
DATA_WIDTH, 16, register width
REG_ADDR_WIDTH, 3, register-file address width (2**REG_ADDR_WIDTH registers dumped)
NUM_BP, 4, number of PC breakpoint comparators (1..16)
CNT_WIDTH, 16, cycle/timeout counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets all state
monitor_en  in  1  arm monitor; IDLE->RUN
pc  in  PC_WIDTH  current core PC
bp_wr_en  in  1  breakpoint config write strobe
bp_wr_idx  in  clog2(NUM_BP)  breakpoint slot
bp_wr_pc  in  PC_WIDTH  breakpoint address
bp_wr_valid  in  1  slot enable written with address
timeout_limit  in  CNT_WIDTH  RUN cycles before timeout; 0 = disabled
resume  in  1  single-cycle pulse; leave HALTED
halt  out  1  core stall request
cause  out  2  0 none, 1 breakpoint, 2 timeout, 3 both same cycle
hit_idx  out  clog2(NUM_BP)  breakpoint slot that fired
hit_pc  out  PC_WIDTH  PC sampled at trigger
reg_rd_addr  out  REG_ADDR_WIDTH  register-file read address
reg_rd_data  in  DATA_WIDTH  register-file read data (combinational, same cycle)
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_idx  out  REG_ADDR_WIDTH  register index of beat
dump_data  out  DATA_WIDTH  register value (= reg_rd_data)
cycle_count  out  CNT_WIDTH  RUN cycles since arming

Behaviour:
- Reset (rst==0 at edge): state IDLE. All bp slots invalid, addresses 0. halt=0, cause=0, hit_idx=0, hit_pc=0, reg_rd_addr=0, dump_valid=0, dump_idx=0, cycle_count=0, suppression flag cleared. Reset mid-DUMP/HALTED aborts immediately and drops halt the same edge.
- FSM IDLE/RUN/DUMP/HALTED, registered.
- IDLE: no counting, no matching. If monitor_en=1, go to RUN and clear cycle_count.
- RUN: if monitor_en=0, go to IDLE. cycle_count increments by 1 per cycle and saturates at all-ones.
  - Breakpoint match: slot valid and pc == slot addr. Lowest index wins.
  - Timeout: timeout_limit!=0 and cycle_count == timeout_limit.
  - On any trigger in cycle T: at T+1, state=DUMP, halt=1, cause/hit_idx/hit_pc latched, reg_rd_addr=dump_idx=0. hit_idx is only updated for breakpoint causes.
- DUMP: dump_valid=1, dump_data=reg_rd_data, reg_rd_addr==dump_idx. A beat transfers when dump_valid && dump_ready; then dump_idx/reg_rd_addr increment. Transfer of the last index (all-ones) goes to HALTED with dump_valid=0. With ready held high, 2**REG_ADDR_WIDTH beats take that many cycles. ready low holds beat stable.
- HALTED: halt=1 and cycle_count held. On resume=1: halt=0 next cycle; next state is RUN if monitor_en else IDLE. cause/hit_pc are kept until the next trigger. resume is ignored outside HALTED.
- Re-trigger suppression: on leaving HALTED a breakpoint cannot fire again while pc == hit_pc. This suppression clears on the first cycle pc != hit_pc. Timeout is not re-triggered: it fires once per arming, and the counter continues from its held value.
- Config writes are accepted in any state and take effect the next cycle. A write of the slot that just fired does not alter latched outputs.
- halt is held continuously from DUMP entry to resume; the core PC must not advance while halt=1.

Test Plan:
1. Reset with rst=0 for 2 cycles during DUMP -> halt=0, dump_valid=0, state IDLE, cycle_count=0 after the first reset edge.
2. bp slot 2 = pc 6, monitor_en=1, program reaches pc 6 -> halt=1 next cycle, cause=1, hit_idx=2, hit_pc=6. 8 beats dump_idx 0..7 with ready high, values match reg_array.
3. Slots 0 and 3 both = pc 10 -> hit_idx=0. dump_ready toggled 1/0 -> each beat is held stable while ready=0, and exactly 8 transfers occur.
4. timeout_limit=400, no breakpoints -> trigger when cycle_count==400, cause=2, dump of all regs, then HALTED. resume leads back to RUN with no second timeout.
5. resume while pc stays at 6 with the bp still valid -> no re-trigger. Loop back to pc 6 after pc changed -> trigger again.
6. Breakpoint at pc 20 and timeout in the same cycle -> cause=3, hit_idx is the bp slot. Config write to slot 1 during HALTED -> it is honoured after resume.
